// File: rtl/dmem_write_buffer.sv
// Posted write buffer between the D-cache line port and slow data memory.
// Dirty-line writebacks are queued and acknowledged in one cycle, drained to
// memory in FIFO order while the port is idle; read misses take priority over
// draining, and reads that hit a queued line are served from the buffer.
module dmem_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    localparam int unsigned ADDR_W = 28,
    localparam int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              wb_empty,
    output logic [PTR_W:0]    wb_count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            entry_q [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [1:0]        state;
    logic [1:0]        state_n;

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              push;
    logic              fwd;
    logic              pop;
    logic              c_ready_n;
    logic [DATA_W-1:0] c_rdata_n;
    logic              mem_read_n;
    logic              mem_write_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic [CNT_W-1:0]  count_n;

    assign head = entry_q[rd_ptr];

    // Associative lookup oldest-to-newest so the last match (newest) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < wb_count) && (entry_q[rd_ptr + PTR_W'(k)].addr == c_addr)) begin
                hit      = 1'b1;
                hit_data = entry_q[rd_ptr + PTR_W'(k)].data;
            end
        end
    end

    // Request acceptance, memory FSM next state and next registered outputs.
    always_comb begin
        state_n     = state;
        mem_read_n  = mem_read;
        mem_write_n = mem_write;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        c_ready_n   = 1'b0;
        c_rdata_n   = c_rdata;
        pop         = 1'b0;
        push        = c_write && !c_ready && (wb_count < CNT_W'(DEPTH));
        fwd         = c_read && !c_ready && hit;

        if (fwd) begin
            c_ready_n = 1'b1;
            c_rdata_n = hit_data;
        end
        if (push) begin
            c_ready_n = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (c_read && !c_ready && !hit) begin
                    state_n    = ST_RD;
                    mem_read_n = 1'b1;
                    mem_addr_n = c_addr;
                end else if (wb_count != '0) begin
                    state_n     = ST_WR;
                    mem_write_n = 1'b1;
                    mem_addr_n  = head.addr;
                    mem_wdata_n = head.data;
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    state_n    = ST_IDLE;
                    mem_read_n = 1'b0;
                    c_ready_n  = 1'b1;
                    c_rdata_n  = mem_rdata;
                end
            end
            ST_WR: begin
                if (mem_ready) begin
                    state_n     = ST_IDLE;
                    mem_write_n = 1'b0;
                    pop         = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        count_n = wb_count + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state, pointers, occupancy and registered outputs.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wb_count  <= '0;
            wb_empty  <= 1'b1;
            c_ready   <= 1'b0;
            c_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            wb_count  <= count_n;
            wb_empty  <= (count_n == '0);
            c_ready   <= c_ready_n;
            c_rdata   <= c_rdata_n;
            mem_read  <= mem_read_n;
            mem_write <= mem_write_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Line storage; written at the tail on every accepted write.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (push) begin
            entry_q[wr_ptr] <= {c_addr, c_wdata};
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench for dmem_write_buffer: tasks queue expected cache responses
// and memory requests; monitors compare whenever the DUT presents them.
module tb_dmem_write_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
    logic         c_read = 1'b0;
    logic         c_write = 1'b0;
    logic [27:0]  c_addr = '0;
    logic [127:0] c_wdata = '0;
    logic [127:0] c_rdata;
    logic         c_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         wb_empty;
    logic [PTR_W:0] wb_count;

    dmem_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_empty(wb_empty), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct { bit rd; logic [127:0] data; } c_exp_t;
    typedef struct { bit wr; logic [27:0] addr; logic [127:0] data; } mem_exp_t;

    c_exp_t   exp_c[$];
    mem_exp_t exp_mem[$];
    int       rdy_log[$];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_cready_cyc = 0;
    int rd_total = 0;
    int rd_rise_cyc = 0;
    int rd_rise_cnt = 0;
    int stray_req = 0;
    int mem_lat = 5;
    bit mem_stall = 1'b0;
    int lat;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [127:0] rdata_of(input logic [27:0] a);
        return {4{4'hE, a}};
    endfunction

    function automatic logic [127:0] line_data(input logic [27:0] a);
        return {4{4'hC, a}};
    endfunction

    function automatic void exp_mem_push(input bit wr, input logic [27:0] a, input logic [127:0] d);
        mem_exp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_mem.push_back(e);
    endfunction

    task automatic cache_write(input logic [27:0] a, input logic [127:0] d, output int l);
        c_exp_t e;
        e.rd = 1'b0; e.data = '0;
        exp_c.push_back(e);
        c_write = 1'b1; c_addr = a; c_wdata = d; l = 0;
        do begin @(negedge clk); l++; end while (c_ready !== 1'b1 && l < 300);
        if (c_ready !== 1'b1) check("write_timeout", 128'(0), 128'(1));
        c_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic cache_read(input logic [27:0] a, input logic [127:0] d, output int l);
        c_exp_t e;
        e.rd = 1'b1; e.data = d;
        exp_c.push_back(e);
        c_read = 1'b1; c_addr = a; l = 0;
        do begin @(negedge clk); l++; end while (c_ready !== 1'b1 && l < 300);
        if (c_ready !== 1'b1) check("read_timeout", 128'(0), 128'(1));
        c_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(wb_empty === 1'b1 && mem_write === 1'b0 && mem_read === 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 128'(n < 500), 128'(1));
        check("drain_count", 128'(wb_count), 128'(0));
    endtask

    // Cache-side monitor: every c_ready pulse must match the oldest expectation.
    initial begin
        c_exp_t ce;
        forever begin
            @(negedge clk);
            if (c_ready === 1'b1) begin
                last_cready_cyc = cyc;
                if (exp_c.size() == 0) check("c_ready_unexpected", 128'(1), 128'(0));
                else begin
                    ce = exp_c.pop_front();
                    if (ce.rd) check("c_rdata", c_rdata, ce.data);
                end
            end
        end
    end

    // Memory-side monitor: each new request is checked against the expected order.
    initial begin
        mem_exp_t me;
        bit prev_rd = 1'b0;
        bit prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if ((mem_read === 1'b1 && !prev_rd) || (mem_write === 1'b1 && !prev_wr)) begin
                check("mem_exclusive", 128'(mem_read & mem_write), 128'(0));
                check("mem_idle_gap", 128'(prev_rd | prev_wr), 128'(0));
                if (exp_mem.size() == 0) check("mem_unexpected", 128'(1), 128'(0));
                else begin
                    me = exp_mem.pop_front();
                    check("mem_kind", 128'(mem_write), 128'(me.wr));
                    check("mem_addr", 128'(mem_addr), 128'(me.addr));
                    if (me.wr) check("mem_wdata", mem_wdata, me.data);
                end
                if (mem_read === 1'b1) begin
                    rd_total++;
                    rd_rise_cyc = cyc;
                    rd_rise_cnt = int'(wb_count);
                end
            end
            prev_rd = (mem_read === 1'b1);
            prev_wr = (mem_write === 1'b1);
        end
    end

    // Slow memory model: answers each request with one mem_ready pulse after mem_lat cycles.
    initial begin
        int rcnt;
        bit rdone;
        int stray_done;
        rcnt = 0; rdone = 1'b0; stray_done = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (proc_reset === 1'b1 || !(mem_read === 1'b1 || mem_write === 1'b1)) begin
                rcnt = 0;
                rdone = 1'b0;
            end else if (!rdone && !mem_stall) begin
                rcnt++;
                if (rcnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata_of(mem_addr);
                    rdone = 1'b1;
                    rdy_log.push_back(cyc);
                end
            end
            if (stray_req != stray_done) begin
                stray_done++;
                mem_ready = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int rd_before;
        int n;

        // Reset then idle
        repeat (3) @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
        check("rst_c_ready", 128'(c_ready), 128'(0));
        check("rst_c_rdata", c_rdata, 128'(0));
        check("rst_mem_read", 128'(mem_read), 128'(0));
        check("rst_mem_write", 128'(mem_write), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        check("rst_mem_wdata", mem_wdata, 128'(0));
        check("rst_wb_empty", 128'(wb_empty), 128'(1));
        check("rst_wb_count", 128'(wb_count), 128'(0));

        // Reset held for 3 cycles while a write is in flight
        mem_stall = 1'b1;
        exp_mem_push(1'b1, 28'h55, line_data(28'h55));
        cache_write(28'h55, line_data(28'h55), lat);
        n = 0;
        while (mem_write !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("wr_started", 128'(mem_write), 128'(1));
        proc_reset = 1'b1;
        @(negedge clk);
        check("rst_wr_drop", 128'(mem_write), 128'(0));
        check("rst_wr_count", 128'(wb_count), 128'(0));
        check("rst_wr_empty", 128'(wb_empty), 128'(1));
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        mem_stall = 1'b0;
        repeat (4) @(negedge clk);
        stray_req++;
        repeat (4) @(negedge clk);
        check("idle_stray_write", 128'(mem_write), 128'(0));
        check("idle_stray_read", 128'(mem_read), 128'(0));
        check("idle_stray_count", 128'(wb_count), 128'(0));

        // Single write
        exp_mem_push(1'b1, 28'h0000010, {4{32'hA5A5_A5A5}});
        cache_write(28'h0000010, {4{32'hA5A5_A5A5}}, lat);
        check("single_wr_lat", 128'(lat), 128'(1));
        wait_drain();
        check("single_wb_empty", 128'(wb_empty), 128'(1));

        // Fill to DEPTH with memory stalled, then a fifth write
        base = rdy_log.size();
        mem_stall = 1'b1;
        for (int i = 1; i <= 5; i++) exp_mem_push(1'b1, 28'(i), line_data(28'(i)));
        for (int i = 1; i <= 4; i++) begin
            cache_write(28'(i), line_data(28'(i)), lat);
            check("fill_wr_lat", 128'(lat), 128'(1));
        end
        check("fill_count", 128'(wb_count), 128'(4));
        check("fill_not_empty", 128'(wb_empty), 128'(0));
        fork
            cache_write(28'd5, line_data(28'd5), lat);
            begin
                repeat (6) @(negedge clk);
                mem_stall = 1'b0;
            end
        join
        check("full_stalled", 128'(lat > 6), 128'(1));
        check("full_accept_after_pop", 128'(last_cready_cyc - rdy_log[base]), 128'(2));
        check("full_refill_count", 128'(wb_count), 128'(4));
        wait_drain();

        // Two writes to one line, then a forwarded read returns the newest
        mem_stall = 1'b1;
        exp_mem_push(1'b1, 28'd7, {4{32'h1111_1111}});
        exp_mem_push(1'b1, 28'd7, {4{32'h2222_2222}});
        rd_before = rd_total;
        cache_write(28'd7, {4{32'h1111_1111}}, lat);
        cache_write(28'd7, {4{32'h2222_2222}}, lat);
        cache_read(28'd7, {4{32'h2222_2222}}, lat);
        check("fwd_lat", 128'(lat), 128'(1));
        mem_stall = 1'b0;
        wait_drain();
        check("fwd_no_mem_read", 128'(rd_total - rd_before), 128'(0));

        // Read miss arrives during a write; it wins over the two queued lines
        base = rdy_log.size();
        mem_stall = 1'b1;
        exp_mem_push(1'b1, 28'h20, line_data(28'h20));
        exp_mem_push(1'b0, 28'd9, '0);
        exp_mem_push(1'b1, 28'h21, line_data(28'h21));
        exp_mem_push(1'b1, 28'h22, line_data(28'h22));
        cache_write(28'h20, line_data(28'h20), lat);
        cache_write(28'h21, line_data(28'h21), lat);
        cache_write(28'h22, line_data(28'h22), lat);
        fork
            cache_read(28'd9, rdata_of(28'd9), lat);
            begin
                repeat (4) @(negedge clk);
                mem_stall = 1'b0;
            end
        join
        check("miss_after_wr_gap", 128'(rd_rise_cyc - rdy_log[base]), 128'(2));
        check("miss_count_at_rd", 128'(rd_rise_cnt), 128'(2));
        check("miss_rdata_lat", 128'(last_cready_cyc - rdy_log[base + 1]), 128'(1));
        wait_drain();

        repeat (3) @(negedge clk);
        check("exp_c_drained", 128'(exp_c.size()), 128'(0));
        check("exp_mem_drained", 128'(exp_mem.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Posted write buffer between the D-cache memory port and slow_memD; CHIP instantiates it on the mem_*_D path.
- It absorbs 128-bit dirty-line writebacks so the cache does not wait for slow-memory write latency.
- It drains the queued lines to memory in FIFO order when the memory port is idle.
- Line reads that hit a queued entry are forwarded from the buffer; reads that miss take priority over draining.

Parameters:
DEPTH, 4, number of line entries; power of two, minimum 2
PTR_W, 2, log2(DEPTH); width of the read and write pointers

Ports:
clk  input  1  single clock; all state on rising edge
proc_reset  input  1  synchronous reset, active-high
c_read  input  1  cache line read request; held until c_ready
c_write  input  1  cache line write request; held until c_ready
c_addr  input  28  line address [31:4]
c_wdata  input  128  write line data
c_rdata  output  128  read line data; valid when c_ready=1 for a read
c_ready  output  1  one-cycle completion pulse to the cache
mem_read  output  1  slow memory read request; held until mem_ready
mem_write  output  1  slow memory write request; held until mem_ready
mem_addr  output  28  slow memory line address
mem_wdata  output  128  slow memory write data
mem_rdata  input  128  slow memory read data; valid with mem_ready
mem_ready  input  1  slow memory completion pulse
wb_empty  output  1  high when no entries are queued
wb_count  output  PTR_W+1  number of queued entries

Behaviour:
- Reset (proc_reset=1 at a clock edge) clears:
  - all entries, pointers and count; wb_empty=1, wb_count=0
  - c_ready=0, c_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0
  - memory FSM to IDLE
- Reset mid-operation drops queued lines and any in-flight request. mem_read/mem_write are low in the cycle after the reset edge. A later mem_ready is ignored while in IDLE.
- Request acceptance: c_read or c_write is treated as a new request only in a cycle where c_ready=0. A request still held during the c_ready cycle is ignored. c_read and c_write are never both high (the cache guarantees this); behaviour is undefined if they are.
- Write accept: new c_write with registered wb_count < DEPTH:
  - push {c_addr, c_wdata} at wr_ptr; wr_ptr wraps modulo DEPTH
  - c_ready=1 in the next cycle
  - latency: exactly 1 cycle
- Full: new c_write with wb_count == DEPTH stalls with no c_ready. It is accepted in the first cycle after a pop makes wb_count < DEPTH. A same-cycle pop does not free a slot for a same-cycle push.
- Read forward: new c_read whose c_addr matches any valid entry:
  - c_rdata = data of the newest matching entry (the one closest to wr_ptr)
  - c_ready=1 in the next cycle; no memory access
  - the entry currently being drained still counts as valid
- Read miss: c_read with no match is held pending until the memory FSM is in IDLE. Then the FSM enters RD: mem_read=1, mem_addr=c_addr.
- Memory FSM states: IDLE, RD, WR.
- IDLE:
  - a pending read miss goes to RD (read has priority)
  - else if wb_count > 0, go to WR with mem_write=1 and mem_addr/mem_wdata taken from the head entry
  - else stay in IDLE
- RD: hold mem_read and mem_addr. On mem_ready:
  - register c_rdata <= mem_rdata
  - c_ready=1 in the next cycle
  - mem_read=0 in the next cycle; return to IDLE
- WR: hold mem_write, mem_addr and mem_wdata; not abortable by a read. On mem_ready:
  - pop head; rd_ptr wraps modulo DEPTH
  - wb_count decrements in the next cycle
  - mem_write=0 in the next cycle; return to IDLE
- mem_read and mem_write are never high simultaneously. There is at least one IDLE cycle between consecutive memory requests.
- Ordering and coherence:
  - drain is strictly FIFO, so repeated writes to one line reach memory oldest first
  - a read never reaches memory while a matching entry is queued
- wb_count increments on push and decrements on pop. A push and a pop in the same cycle leave it unchanged. wb_empty = (wb_count == 0).

Test Plan:
- Reset then idle: outputs all 0, wb_empty=1; hold proc_reset high 3 cycles during WR -> mem_write=0 the cycle after the first reset edge, wb_count=0.
- Single write 0x0000010 / data 0xA5..A5 with mem_ready 5 cycles after mem_write -> c_ready exactly 1 cycle after request, one mem_write with matching addr/data, wb_empty=1 after the pop.
- Four writes (addresses 1,2,3,4) with memory stalled, then a fifth write -> fifth is not acknowledged until the first mem_ready; memory then sees 1,2,3,4,5 in order.
- Writes to line 7 with data X then Y, then read line 7 -> c_rdata=Y one cycle after the read; mem_read never asserted.
- Read miss line 9 while 2 entries are queued and the FSM is in IDLE -> mem_read issued before any mem_write; c_rdata equals mem_rdata one cycle after mem_ready; drain then resumes.
- Read miss arriving during WR -> mem_read asserted only after that write's mem_ready plus one IDLE cycle; wb_count decremented by 1.
